seg_scan_ctrl: RTL and testbench

- Scan controller for the 8-digit hex display path. It sits directly upstream of the 8:1 x 4-bit display multiplexer.
- Latches a 32-bit display word and presents it as eight 4-bit nibbles (x0..x7) to the mux. Drives the mux select (sel) with a prescaled rotating digit index.
- Generates active-low digit anodes with dead-time and per-digit blanking.
- Display updates are tear-free: a new word takes effect only at a frame boundary.

---
 rtl/seg_scan_ctrl_if.sv | 20 ++
 rtl/seg_scan_ctrl.sv | 73 +++++++
 tb/tb_seg_scan_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: control inputs and mux/anode outputs of the 8-digit scan controller.
interface seg_scan_ctrl_if;
    logic        en;
    logic        load;
    logic [31:0] din;
    logic [7:0]  blank_mask;
    logic [3:0]  x0, x1, x2, x3, x4, x5, x6, x7;
    logic [2:0]  sel;
    logic [7:0]  an;
    logic        load_ack;
    logic        frame_done;
    modport master (
        output en, load, din, blank_mask,
        input  x0, x1, x2, x3, x4, x5, x6, x7, sel, an, load_ack, frame_done
    );
    modport slave (
        input  en, load, din, blank_mask,
        output x0, x1, x2, x3, x4, x5, x6, x7, sel, an, load_ack, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: prescaled digit scanner with dead-time anodes and frame-synchronous word update.
module seg_scan_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int DEAD    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] r_div_cnt;
    logic [2:0]    r_sel;
    logic [31:0]   r_disp;
    logic [31:0]   r_pend;
    logic          r_pend_valid;
    logic          r_load_ack;
    logic          r_frame_done;
    logic          w_wrap;
    logic          w_frame;
    logic          w_apply;
    logic          w_on;

    assign w_wrap  = bus.en && (r_div_cnt == DW'(CLK_DIV - 1));
    assign w_frame = w_wrap && (r_sel == 3'd7);
    // the display word may only change while scanning is idle or between frames
    assign w_apply = w_frame || !bus.en;
    assign w_on    = rst_n && bus.en && (r_div_cnt >= DW'(DEAD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_sel        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_div_cnt    <= (!bus.en || w_wrap) ? '0 : r_div_cnt + 1'b1;
            r_sel        <= !bus.en ? 3'd0 : w_wrap ? r_sel + 3'd1 : r_sel;
            r_frame_done <= w_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_load_ack   <= 1'b0;
        end else if (w_apply && (bus.load || r_pend_valid)) begin
            r_disp       <= bus.load ? bus.din : r_pend;
            r_pend_valid <= 1'b0;
            r_load_ack   <= 1'b1;
        end else begin
            r_load_ack   <= 1'b0;
            if (bus.load) begin
                r_pend       <= bus.din;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign bus.an         = w_on ? (~(8'd1 << r_sel) | bus.blank_mask) : 8'hFF;
    assign bus.sel        = r_sel;
    assign bus.load_ack   = r_load_ack;
    assign bus.frame_done = r_frame_done;
    assign bus.x0         = r_disp[3:0];
    assign bus.x1         = r_disp[7:4];
    assign bus.x2         = r_disp[11:8];
    assign bus.x3         = r_disp[15:12];
    assign bus.x4         = r_disp[19:16];
    assign bus.x5         = r_disp[23:20];
    assign bus.x6         = r_disp[27:24];
    assign bus.x7         = r_disp[31:28];
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan timing, anode decode, tear-free loading and reset.
module tb_seg_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int t = 0;
    int acks = 0;
    logic [31:0] xw;

    always #5 clk = ~clk;

    seg_scan_ctrl_if bus();
    seg_scan_ctrl #(.CLK_DIV(4), .DEAD(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    assign xw = {bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        t++;
    endtask

    // slot layout: one dark cycle then three lit cycles per digit, blanked digits stay dark
    function automatic logic [7:0] exp_an(input int tt, input logic [7:0] bm);
        int s;
        s = (tt / 4) % 8;
        return (tt % 4 == 0) ? 8'hFF : (~(8'd1 << s) | bm);
    endfunction

    initial begin
        bus.en = 1'b1;
        bus.load = 1'b0;
        bus.din = '0;
        bus.blank_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_an", 32'(bus.an), 32'hFF);
        chk("rst_x", xw, 0);
        chk("rst_ack", 32'(bus.load_ack), 0);
        chk("rst_fd", 32'(bus.frame_done), 0);
        rst_n = 1'b1;
        t = 0;
        for (int i = 0; i < 64; i++) begin
            chk("scan_sel", 32'(bus.sel), 32'((t / 4) % 8));
            chk("scan_an", 32'(bus.an), 32'(exp_an(t, 8'h00)));
            chk("scan_fd", 32'(bus.frame_done), 32'(t > 0 && t % 32 == 0));
            step();
        end
        chk("fd_64", 32'(bus.frame_done), 1);
        while (t < 72) step();
        bus.load = 1'b1;
        bus.din = 32'h76543210;
        step();
        bus.load = 1'b0;
        while (t < 96) begin
            chk("tear_x", xw, 0);
            chk("tear_ack", 32'(bus.load_ack), 0);
            step();
        end
        chk("apply_x", xw, 32'h76543210);
        chk("apply_ack", 32'(bus.load_ack), 1);
        chk("apply_fd", 32'(bus.frame_done), 1);
        step();
        chk("apply_ack_end", 32'(bus.load_ack), 0);
        while (t < 100) step();
        bus.load = 1'b1;
        bus.din = 32'h11111111;
        step();
        bus.load = 1'b0;
        while (t < 110) step();
        bus.load = 1'b1;
        bus.din = 32'h89ABCDEF;
        step();
        bus.load = 1'b0;
        acks = 0;
        while (t < 140) begin
            if (t == 127) chk("ovw_hold", xw, 32'h76543210);
            if (t == 128) begin
                chk("ovw_x", xw, 32'h89ABCDEF);
                chk("ovw_ack", 32'(bus.load_ack), 1);
            end
            if (bus.load_ack) acks++;
            step();
        end
        chk("ovw_ack_count", 32'(acks), 1);
        bus.en = 1'b0;
        step();
        chk("dis_sel", 32'(bus.sel), 0);
        chk("dis_an", 32'(bus.an), 32'hFF);
        bus.load = 1'b1;
        bus.din = 32'hFEDCBA98;
        step();
        bus.load = 1'b0;
        chk("dis_x", xw, 32'hFEDCBA98);
        chk("dis_ack", 32'(bus.load_ack), 1);
        chk("dis_an2", 32'(bus.an), 32'hFF);
        chk("dis_sel2", 32'(bus.sel), 0);
        chk("dis_fd", 32'(bus.frame_done), 0);
        step();
        chk("dis_ack_end", 32'(bus.load_ack), 0);
        chk("dis_x_keep", xw, 32'hFEDCBA98);
        bus.en = 1'b1;
        bus.blank_mask = 8'h80;
        t = 0;
        for (int i = 0; i < 64; i++) begin
            chk("blank_sel", 32'(bus.sel), 32'((t / 4) % 8));
            chk("blank_an", 32'(bus.an), 32'(exp_an(t, 8'h80)));
            step();
        end
        while (t < 70) step();
        bus.load = 1'b1;
        bus.din = 32'h12345678;
        step();
        bus.load = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(bus.sel), 0);
        chk("mid_rst_an", 32'(bus.an), 32'hFF);
        chk("mid_rst_x", xw, 0);
        chk("mid_rst_ack", 32'(bus.load_ack), 0);
        chk("mid_rst_fd", 32'(bus.frame_done), 0);
        repeat (2) step();
        rst_n = 1'b1;
        acks = 0;
        repeat (40) begin
            if (bus.load_ack) acks++;
            step();
        end
        chk("post_rst_acks", 32'(acks), 0);
        chk("post_rst_x", xw, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
